vote_input_conditioner: RTL and testbench

- Front-end stage directly upstream of `voting_machine`.
- Takes three raw, asynchronous candidate push-buttons and a raw voting-over switch.
- Synchronises and debounces each button, then enforces one vote per press-and-release.
- Drives single-cycle, mutually exclusive `o_candidate_1..3` strobes and a sticky closed flag, which feed the counter's `i_candidate_*` and `i_voting_over` inputs.

---
 rtl/voting_pkg.sv | 30 +++
 rtl/btn_sync_debounce.sv | 40 ++++
 rtl/vote_input_conditioner.sv | 129 ++++++++++++
 tb/tb_vote_input_conditioner.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/voting_pkg.sv
// Shared definitions for the voting front end and counter.
// Candidate count, FSM state encoding and small vote-decoding helpers.
package voting_pkg;

   localparam int NUM_CAND   = 3;
   localparam int CAND_IDX_W = 2;

   typedef enum logic [2:0] {
      IDLE,
      ACCEPT,
      REJECT,
      WAIT_REL,
      CLOSED
   } vic_state_t;

   // True when exactly one bit of the debounced button vector is set.
   function automatic logic is_single(input logic [NUM_CAND-1:0] v);
      return (v != '0) && ((v & (v - NUM_CAND'(1))) == '0);
   endfunction

   function automatic logic [CAND_IDX_W-1:0] cand_index(input logic [NUM_CAND-1:0] v);
      logic [CAND_IDX_W-1:0] idx;
      idx = '0;
      for (int i = 0; i < NUM_CAND; i++) begin
         if (v[i]) idx = CAND_IDX_W'(i);
      end
      return idx;
   endfunction

endpackage

// File: rtl/btn_sync_debounce.sv
// Two-flop synchroniser followed by a counting debouncer for one raw button.
// The debounced level only follows the synchronised level after DEBOUNCE_CYCLES stable disagreeing samples.
module btn_sync_debounce #(
   parameter int DEBOUNCE_CYCLES = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic i_raw,
   output logic s,
   output logic db
);

   localparam int                CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             meta_p0;
   logic [CNT_W-1:0] cnt;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         meta_p0 <= 1'b0;
         s       <= 1'b0;
         db      <= 1'b0;
         cnt     <= '0;
      end else begin
         meta_p0 <= i_raw;
         s       <= meta_p0;
         // Any sample agreeing with the held level restarts the stability count.
         if (s == db) begin
            cnt <= '0;
         end else if (cnt == CNT_LAST) begin
            db  <= s;
            cnt <= '0;
         end else begin
            cnt <= cnt + CNT_W'(1);
         end
      end
   end

endmodule

// File: rtl/vote_input_conditioner.sv
// Conditions raw candidate buttons and the close-poll switch into clean,
// single-cycle, mutually exclusive vote strobes plus a sticky closed flag.
module vote_input_conditioner
   import voting_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic i_btn_1,
   input  logic i_btn_2,
   input  logic i_btn_3,
   input  logic i_voting_over,
   output logic o_candidate_1,
   output logic o_candidate_2,
   output logic o_candidate_3,
   output logic o_reject,
   output logic o_busy,
   output logic o_closed
);

   logic [NUM_CAND-1:0] btn_raw;
   logic [NUM_CAND-1:0] btn_db;
   logic [NUM_CAND-1:0] btn_s_unused;

   assign btn_raw = {i_btn_3, i_btn_2, i_btn_1};

   for (genvar k = 0; k < NUM_CAND; k++) begin : g_btn
      btn_sync_debounce #(
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_btn (
         .clk   (clk),
         .rst   (rst),
         .i_raw (btn_raw[k]),
         .s     (btn_s_unused[k]),
         .db    (btn_db[k])
      );
   end

   // Voting-over only ever closes the poll, so one synchronised high sample is latched for good.
   logic vo_p0;
   logic vo_p1;
   logic vo_seen_p2;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         vo_p0      <= 1'b0;
         vo_p1      <= 1'b0;
         vo_seen_p2 <= 1'b0;
      end else begin
         vo_p0      <= i_voting_over;
         vo_p1      <= vo_p0;
         vo_seen_p2 <= vo_seen_p2 | vo_p1;
      end
   end

   vic_state_t            state;
   vic_state_t            state_nxt;
   logic [CAND_IDX_W-1:0] sel;
   logic [CAND_IDX_W-1:0] sel_nxt;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
         sel   <= '0;
      end else begin
         state <= state_nxt;
         sel   <= sel_nxt;
      end
   end

   always_comb begin
      state_nxt     = state;
      sel_nxt       = sel;
      o_candidate_1 = 1'b0;
      o_candidate_2 = 1'b0;
      o_candidate_3 = 1'b0;
      o_reject      = 1'b0;
      o_busy        = 1'b0;
      o_closed      = 1'b0;

      unique case (state)
         IDLE: begin
            if (vo_seen_p2) begin
               state_nxt = CLOSED;
            end else if (btn_db == '0) begin
               state_nxt = IDLE;
            end else if (is_single(btn_db)) begin
               state_nxt = ACCEPT;
               sel_nxt   = cand_index(btn_db);
            end else begin
               state_nxt = REJECT;
            end
         end

         // A started accept always emits its strobe, even if the poll closes meanwhile.
         ACCEPT: begin
            o_candidate_1 = (sel == CAND_IDX_W'(0));
            o_candidate_2 = (sel == CAND_IDX_W'(1));
            o_candidate_3 = (sel == CAND_IDX_W'(2));
            state_nxt     = vo_seen_p2 ? CLOSED : WAIT_REL;
         end

         REJECT: begin
            o_reject  = 1'b1;
            state_nxt = vo_seen_p2 ? CLOSED : WAIT_REL;
         end

         // Stay here until every button is released so held or extra presses never vote.
         WAIT_REL: begin
            o_busy = 1'b1;
            if (vo_seen_p2) begin
               state_nxt = CLOSED;
            end else if (btn_db == '0) begin
               state_nxt = IDLE;
            end
         end

         CLOSED: begin
            o_closed = 1'b1;
         end

         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_vote_input_conditioner.sv
// Directed bench for vote_input_conditioner: stimulus queues expected output
// events, a negedge monitor matches every strobe/closed-rise against that queue.
module tb_vote_input_conditioner;

   localparam int DB   = 4;
   localparam int LAT  = DB + 3;   // drive cycle to candidate/reject strobe
   localparam int VLAT = 4;        // drive cycle to o_closed

   localparam int EV_C1     = 1;
   localparam int EV_C2     = 2;
   localparam int EV_C3     = 3;
   localparam int EV_REJ    = 4;
   localparam int EV_CLOSED = 5;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic i_btn_1 = 1'b0;
   logic i_btn_2 = 1'b0;
   logic i_btn_3 = 1'b0;
   logic i_voting_over = 1'b0;
   logic o_candidate_1, o_candidate_2, o_candidate_3;
   logic o_reject, o_busy, o_closed;

   vote_input_conditioner #(
      .DEBOUNCE_CYCLES(DB)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .i_btn_1       (i_btn_1),
      .i_btn_2       (i_btn_2),
      .i_btn_3       (i_btn_3),
      .i_voting_over (i_voting_over),
      .o_candidate_1 (o_candidate_1),
      .o_candidate_2 (o_candidate_2),
      .o_candidate_3 (o_candidate_3),
      .o_reject      (o_reject),
      .o_busy        (o_busy),
      .o_closed      (o_closed)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int kind;
      int at;
   } exp_t;

   exp_t exp_q[$];
   int   errors = 0;
   int   checks = 0;
   int   tally[3] = '{0, 0, 0};
   bit   prev_closed = 1'b0;

   task automatic check(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
      end
   endtask

   task automatic expect_ev(input int kind, input int at);
      exp_t e;
      e.kind = kind;
      e.at   = at;
      exp_q.push_back(e);
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   function automatic int outs();
      return int'({o_candidate_1, o_candidate_2, o_candidate_3, o_reject, o_busy, o_closed});
   endfunction

   task automatic record(input int kind);
      exp_t e;
      if (exp_q.size() == 0) begin
         check("unexpected_event", kind, 0);
      end else begin
         e = exp_q.pop_front();
         check("event_kind", kind, e.kind);
         check("event_cycle", cyc, e.at);
      end
   endtask

   // Monitor: every output event must match the head of the expectation queue.
   always @(negedge clk) begin : mon
      int n;
      n = int'(o_candidate_1) + int'(o_candidate_2) + int'(o_candidate_3) + int'(o_reject);
      if (n > 1) check("exclusive_strobes", n, 1);
      if (o_candidate_1) begin record(EV_C1); tally[0]++; end
      else if (o_candidate_2) begin record(EV_C2); tally[1]++; end
      else if (o_candidate_3) begin record(EV_C3); tally[2]++; end
      else if (o_reject) record(EV_REJ);
      if (o_closed && !prev_closed) record(EV_CLOSED);
      prev_closed = o_closed;
   end

   task automatic set_btn(input int k, input logic v);
      case (k)
         1: i_btn_1 = v;
         2: i_btn_2 = v;
         default: i_btn_3 = v;
      endcase
   endtask

   initial begin : watchdog
      #1000000;
      $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
      $fatal(1);
   end

   initial begin : stim
      int n;
      int base[3];
      int seq[8] = '{1, 2, 1, 3, 2, 2, 1, 3};
      int bounce_v[6] = '{1, 0, 1, 0, 1, 0};
      int bounce_n[6] = '{1, 1, 2, 1, 3, 2};

      // Reset
      #1 rst = 1'b0;
      step(3);
      check("reset_outputs", outs(), 0);
      rst = 1'b1;
      step(10);
      check("idle_outputs", outs(), 0);

      // Clean press of button 2
      n = cyc;
      i_btn_2 = 1'b1;
      expect_ev(EV_C2, n + LAT);
      step(LAT);
      check("busy_during_accept", int'(o_busy), 0);
      step(1);
      check("busy_after_accept", int'(o_busy), 1);
      step(12 - LAT - 1);
      n = cyc;
      i_btn_2 = 1'b0;
      step(6);
      check("busy_before_release_done", int'(o_busy), 1);
      step(1);
      check("busy_cleared", int'(o_busy), 0);
      step(5);

      // Short glitches on button 1 never vote
      for (int g = 0; g < 2; g++) begin
         i_btn_1 = 1'b1;
         step(2);
         i_btn_1 = 1'b0;
         step(6);
      end
      check("glitch_no_busy", int'(o_busy), 0);

      // Bouncy press that settles high
      for (int b = 0; b < 6; b++) begin
         i_btn_1 = bounce_v[b][0];
         step(bounce_n[b]);
      end
      n = cyc;
      i_btn_1 = 1'b1;
      expect_ev(EV_C1, n + LAT);
      step(12);
      i_btn_1 = 1'b0;
      step(8);

      // Simultaneous press of 1 and 3 is rejected
      n = cyc;
      i_btn_1 = 1'b1;
      i_btn_3 = 1'b1;
      expect_ev(EV_REJ, n + LAT);
      step(LAT + 1);
      check("busy_after_reject", int'(o_busy), 1);
      step(3);
      i_btn_1 = 1'b0;
      i_btn_3 = 1'b0;
      step(8);
      n = cyc;
      i_btn_3 = 1'b1;
      expect_ev(EV_C3, n + LAT);
      step(10);
      i_btn_3 = 1'b0;
      step(8);

      // Staggered presses: first debounced button wins, second is ignored
      n = cyc;
      i_btn_1 = 1'b1;
      expect_ev(EV_C1, n + LAT);
      step(2);
      i_btn_2 = 1'b1;
      step(10);
      i_btn_1 = 1'b0;
      i_btn_2 = 1'b0;
      step(8);

      // Vote sequence into the counter
      base[0] = tally[0];
      base[1] = tally[1];
      base[2] = tally[2];
      for (int v = 0; v < 8; v++) begin
         n = cyc;
         set_btn(seq[v], 1'b1);
         expect_ev(seq[v], n + LAT);
         step(8);
         set_btn(seq[v], 1'b0);
         step(8);
      end
      step(2);
      check("count_cand1", tally[0] - base[0], 3);
      check("count_cand2", tally[1] - base[1], 3);
      check("count_cand3", tally[2] - base[2], 2);

      // Voting over
      n = cyc;
      i_voting_over = 1'b1;
      expect_ev(EV_CLOSED, n + VLAT);
      step(VLAT - 1);
      check("closed_not_yet", int'(o_closed), 0);
      step(1);
      check("closed_set", int'(o_closed), 1);
      i_btn_1 = 1'b1;
      step(12);
      i_btn_1 = 1'b0;
      check("closed_sticky", int'(o_closed), 1);
      i_voting_over = 1'b0;
      step(4);
      check("closed_sticky_after_switch_low", int'(o_closed), 1);
      rst = 1'b0;
      #1;
      check("closed_cleared_by_reset", int'(o_closed), 0);
      step(2);
      rst = 1'b1;
      step(10);
      check("outputs_after_reopen", outs(), 0);

      // Reset during an accept drops the strobe immediately
      n = cyc;
      i_btn_2 = 1'b1;
      step(LAT);
      check("strobe_before_reset", int'(o_candidate_2), 1);
      rst = 1'b0;
      #1;
      check("strobe_dropped_by_reset", int'(o_candidate_2), 0);
      i_btn_2 = 1'b0;
      step(2);
      rst = 1'b1;
      step(10);
      check("outputs_after_mid_reset", outs(), 0);

      step(5);
      check("expectations_drained", exp_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
